vga_bounce_box: RTL and testbench

//  Pixel-source stage directly upstream of vga_controller on the clk_px domain.

---
 rtl/vga_bounce_box.sv | 160 ++++++++++++++++
 tb/tb_vga_bounce_box.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_bounce_box.sv
// Pixel source for vga_controller: a solid box bouncing inside the active area over an
// optional blue grid, one clock of latency from scan position to RGB.
module vga_bounce_box #(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned BOX_W     = 32,
    parameter int unsigned BOX_H     = 32,
    parameter int unsigned STEP      = 2,
    parameter int unsigned GRID_LOG2 = 6
) (
    input  logic        clk_px,
    input  logic        i_reset,
    input  logic [10:0] i_pos_h,
    input  logic [9:0]  i_pos_v,
    input  logic        i_pause,
    input  logic        i_grid_en,
    output logic        o_red,
    output logic        o_green,
    output logic        o_blue,
    output logic [10:0] o_box_x,
    output logic [9:0]  o_box_y,
    output logic        o_frame_tick
);

    localparam logic [11:0] XMAX12 = 12'(H_ACTIVE - BOX_W);
    localparam logic [11:0] YMAX12 = 12'(V_ACTIVE - BOX_H);
    localparam logic [10:0] XMAX   = 11'(H_ACTIVE - BOX_W);
    localparam logic [9:0]  YMAX   = 10'(V_ACTIVE - BOX_H);
    localparam logic [11:0] STEP12 = 12'(STEP);
    localparam logic [10:0] STEP_X = 11'(STEP);
    localparam logic [9:0]  STEP_Y = 10'(STEP);

    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic        r_dir_x_neg;
    logic        r_dir_y_neg;
    logic [2:0]  r_colour;
    logic        r_prev_origin;
    logic [2:0]  r_rgb;
    logic        r_tick;

    logic        w_origin;
    logic        w_fs;
    logic [11:0] w_x12;
    logic [11:0] w_y12;
    logic [11:0] w_h12;
    logic [11:0] w_v12;
    logic [10:0] w_x_nxt;
    logic [9:0]  w_y_nxt;
    logic        w_dir_x_nxt;
    logic        w_dir_y_nxt;
    logic        w_bounce_x;
    logic        w_bounce_y;
    logic        w_active;
    logic        w_in_box;
    logic        w_grid;
    logic [2:0]  w_rgb;

    assign w_origin = (i_pos_h == 11'd0) && (i_pos_v == 10'd0);
    assign w_fs     = w_origin && !r_prev_origin;
    assign w_x12    = {1'b0, r_x};
    assign w_y12    = {2'b00, r_y};
    assign w_h12    = {1'b0, i_pos_h};
    assign w_v12    = {2'b00, i_pos_v};

    // Comparisons run in 12 bits so the edge tests never wrap.
    always_comb begin
        w_x_nxt     = r_x;
        w_dir_x_nxt = r_dir_x_neg;
        w_bounce_x  = 1'b0;
        if (!r_dir_x_neg) begin
            if (w_x12 + STEP12 >= XMAX12) begin
                w_x_nxt     = XMAX;
                w_dir_x_nxt = 1'b1;
                w_bounce_x  = 1'b1;
            end else begin
                w_x_nxt = r_x + STEP_X;
            end
        end else if (w_x12 <= STEP12) begin
            w_x_nxt     = 11'd0;
            w_dir_x_nxt = 1'b0;
            w_bounce_x  = 1'b1;
        end else begin
            w_x_nxt = r_x - STEP_X;
        end
    end

    always_comb begin
        w_y_nxt     = r_y;
        w_dir_y_nxt = r_dir_y_neg;
        w_bounce_y  = 1'b0;
        if (!r_dir_y_neg) begin
            if (w_y12 + STEP12 >= YMAX12) begin
                w_y_nxt     = YMAX;
                w_dir_y_nxt = 1'b1;
                w_bounce_y  = 1'b1;
            end else begin
                w_y_nxt = r_y + STEP_Y;
            end
        end else if (w_y12 <= STEP12) begin
            w_y_nxt     = 10'd0;
            w_dir_y_nxt = 1'b0;
            w_bounce_y  = 1'b1;
        end else begin
            w_y_nxt = r_y - STEP_Y;
        end
    end

    assign w_active = (w_h12 < 12'(H_ACTIVE)) && (w_v12 < 12'(V_ACTIVE));
    assign w_in_box = (w_h12 >= w_x12) && (w_h12 < w_x12 + 12'(BOX_W)) &&
                      (w_v12 >= w_y12) && (w_v12 < w_y12 + 12'(BOX_H));
    assign w_grid   = i_grid_en && ((i_pos_h[GRID_LOG2-1:0] == '0) ||
                                    (i_pos_v[GRID_LOG2-1:0] == '0));

    always_comb begin
        w_rgb = 3'b000;
        if (w_active) begin
            if (w_in_box) begin
                w_rgb = r_colour;
            end else if (w_grid) begin
                w_rgb = 3'b001;
            end
        end
    end

    always_ff @(posedge clk_px) begin
        if (i_reset) begin
            r_x           <= 11'd0;
            r_y           <= 10'd0;
            r_dir_x_neg   <= 1'b0;
            r_dir_y_neg   <= 1'b0;
            r_colour      <= 3'b100;
            r_prev_origin <= 1'b1;
            r_rgb         <= 3'b000;
            r_tick        <= 1'b0;
        end else begin
            r_prev_origin <= w_origin;
            r_rgb         <= w_rgb;
            r_tick        <= w_fs;
            // Pause only blocks motion; the tick still marks the frame.
            if (w_fs && !i_pause) begin
                r_x         <= w_x_nxt;
                r_y         <= w_y_nxt;
                r_dir_x_neg <= w_dir_x_nxt;
                r_dir_y_neg <= w_dir_y_nxt;
                if (w_bounce_x || w_bounce_y) begin
                    r_colour <= r_colour + 3'd1;
                end
            end
        end
    end

    assign o_red        = r_rgb[2];
    assign o_green      = r_rgb[1];
    assign o_blue       = r_rgb[0];
    assign o_box_x      = r_x;
    assign o_box_y      = r_y;
    assign o_frame_tick = r_tick;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Bench for vga_bounce_box: a behavioural model feeds a scoreboard queue each cycle, plus
// scenario tasks with fixed expected values; a second instance exercises a corner bounce.
module tb_vga_bounce_box;

    localparam int H_ACT = 800;
    localparam int V_ACT = 600;
    localparam int BOX   = 32;
    localparam int STP   = 2;
    localparam int XMAX  = H_ACT - BOX;
    localparam int YMAX  = V_ACT - BOX;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [10:0] i_pos_h = '0;
    logic [9:0]  i_pos_v = '0;
    logic        i_pause = 1'b0;
    logic        i_grid_en = 1'b0;
    logic        o_red, o_green, o_blue, o_frame_tick;
    logic [10:0] o_box_x;
    logic [9:0]  o_box_y;
    logic        c_red, c_green, c_blue, c_tick;
    logic [10:0] c_box_x;
    logic [9:0]  c_box_y;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0]  rgb;
        logic        tick;
        logic [10:0] bx;
        logic [9:0]  by;
    } exp_t;
    exp_t sb_q[$];

    // Model state
    int         m_x, m_y;
    logic       m_dxn, m_dyn, m_prev;
    logic [2:0] m_col;

    vga_bounce_box u_dut (
        .clk_px(clk), .i_reset(i_reset), .i_pos_h(i_pos_h), .i_pos_v(i_pos_v),
        .i_pause(i_pause), .i_grid_en(i_grid_en), .o_red(o_red), .o_green(o_green),
        .o_blue(o_blue), .o_box_x(o_box_x), .o_box_y(o_box_y), .o_frame_tick(o_frame_tick)
    );

    // Square active area so X and Y reach their limits on the same frame.
    vga_bounce_box #(.H_ACTIVE(600)) u_dut_c (
        .clk_px(clk), .i_reset(i_reset), .i_pos_h(i_pos_h), .i_pos_v(i_pos_v),
        .i_pause(i_pause), .i_grid_en(i_grid_en), .o_red(c_red), .o_green(c_green),
        .o_blue(c_blue), .o_box_x(c_box_x), .o_box_y(c_box_y), .o_frame_tick(c_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model_pixel(int h, int v);
        if (h >= H_ACT || v >= V_ACT) return 3'b000;
        if (h >= m_x && h < m_x + BOX && v >= m_y && v < m_y + BOX) return m_col;
        if (i_grid_en && ((h % 64) == 0 || (v % 64) == 0)) return 3'b001;
        return 3'b000;
    endfunction

    task automatic model_move();
        logic bx = 1'b0;
        logic by = 1'b0;
        if (!m_dxn) begin
            if (m_x + STP >= XMAX) begin m_x = XMAX; m_dxn = 1'b1; bx = 1'b1; end
            else m_x = m_x + STP;
        end else begin
            if (m_x <= STP) begin m_x = 0; m_dxn = 1'b0; bx = 1'b1; end
            else m_x = m_x - STP;
        end
        if (!m_dyn) begin
            if (m_y + STP >= YMAX) begin m_y = YMAX; m_dyn = 1'b1; by = 1'b1; end
            else m_y = m_y + STP;
        end else begin
            if (m_y <= STP) begin m_y = 0; m_dyn = 1'b0; by = 1'b1; end
            else m_y = m_y - STP;
        end
        if (bx || by) m_col = m_col + 3'd1;
    endtask

    // Drive one pixel position for one clock; the expected outputs go on the queue.
    task automatic step(input int h, input int v);
        exp_t e;
        logic origin;
        i_pos_h = 11'(h);
        i_pos_v = 10'(v);
        origin = (h == 0) && (v == 0);
        if (i_reset) begin
            m_x = 0; m_y = 0; m_dxn = 1'b0; m_dyn = 1'b0; m_col = 3'b100; m_prev = 1'b1;
            e = '{rgb: 3'b000, tick: 1'b0, bx: 11'd0, by: 10'd0};
        end else begin
            e.rgb  = model_pixel(h, v);
            e.tick = origin && !m_prev;
            m_prev = origin;
            if (e.tick && !i_pause) model_move();
            e.bx = 11'(m_x);
            e.by = 10'(m_y);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        step(0, 0);
        step(1, 0);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if ({o_red, o_green, o_blue} !== e.rgb) begin
                n_fail++;
                $display("FAIL sb_rgb: got %b want %b", {o_red, o_green, o_blue}, e.rgb);
            end
            n_checks++;
            if (o_frame_tick !== e.tick) begin
                n_fail++;
                $display("FAIL sb_tick: got %b want %b", o_frame_tick, e.tick);
            end
            n_checks++;
            if (o_box_x !== e.bx || o_box_y !== e.by) begin
                n_fail++;
                $display("FAIL sb_box: got (%0d,%0d) want (%0d,%0d)",
                         o_box_x, o_box_y, e.bx, e.by);
            end
        end
    end

    task automatic test_reset();
        i_reset = 1'b1;
        step(0, 0);
        step(0, 0);
        n_checks++;
        if ({o_red, o_green, o_blue, o_frame_tick} !== 4'b0 || o_box_x !== 11'd0
            || o_box_y !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_state: got rgb=%b tick=%b box=(%0d,%0d) want zeros",
                     {o_red, o_green, o_blue}, o_frame_tick, o_box_x, o_box_y);
        end
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            n_checks++;
            if (o_frame_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL origin_hold_tick: got %b want 0", o_frame_tick);
            end
        end
        step(1, 0);
    endtask

    task automatic test_frames();
        for (int f = 1; f <= 3; f++) begin
            step(0, 0);
            n_checks++;
            if (o_frame_tick !== 1'b1 || o_box_x !== 11'(2 * f) || o_box_y !== 10'(2 * f)) begin
                n_fail++;
                $display("FAIL frame_%0d: got tick=%b box=(%0d,%0d) want 1 (%0d,%0d)",
                         f, o_frame_tick, o_box_x, o_box_y, 2 * f, 2 * f);
            end
            step(1, 0);
            n_checks++;
            if (o_frame_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL tick_width: got %b want 0", o_frame_tick);
            end
        end
    endtask

    task automatic test_pixels();
        int guard = 0;
        while (m_x != 100 && guard < 200) begin frame(); guard++; end
        n_checks++;
        if (o_box_x !== 11'd100 || o_box_y !== 10'd100) begin
            n_fail++;
            $display("FAIL reach_100: got (%0d,%0d) want (100,100)", o_box_x, o_box_y);
        end
        i_grid_en = 1'b0;
        step(100, 100);
        n_checks++;
        if ({o_red, o_green, o_blue} !== 3'b100) begin
            n_fail++;
            $display("FAIL px_box_corner: got %b want 100", {o_red, o_green, o_blue});
        end
        step(132, 100);
        n_checks++;
        if ({o_red, o_green, o_blue} !== 3'b000) begin
            n_fail++;
            $display("FAIL px_right_edge: got %b want 000", {o_red, o_green, o_blue});
        end
        step(131, 131);
        n_checks++;
        if ({o_red, o_green, o_blue} !== 3'b100) begin
            n_fail++;
            $display("FAIL px_box_last: got %b want 100", {o_red, o_green, o_blue});
        end
        i_grid_en = 1'b1;
        step(128, 70);
        n_checks++;
        if ({o_red, o_green, o_blue} !== 3'b001) begin
            n_fail++;
            $display("FAIL px_grid: got %b want 001", {o_red, o_green, o_blue});
        end
        step(800, 0);
        n_checks++;
        if ({o_red, o_green, o_blue} !== 3'b000) begin
            n_fail++;
            $display("FAIL px_blank: got %b want 000", {o_red, o_green, o_blue});
        end
    endtask

    task automatic test_pause();
        logic [10:0] bx;
        logic [9:0]  by;
        bx = o_box_x;
        by = o_box_y;
        i_pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            n_checks++;
            if (o_frame_tick !== 1'b1 || o_box_x !== bx || o_box_y !== by) begin
                n_fail++;
                $display("FAIL pause_%0d: got tick=%b box=(%0d,%0d) want 1 (%0d,%0d)",
                         i, o_frame_tick, o_box_x, o_box_y, bx, by);
            end
            step(1, 0);
        end
        i_pause = 1'b0;
        step(0, 0);
        n_checks++;
        if (o_box_x !== bx + 11'd2 || o_box_y !== by + 10'd2) begin
            n_fail++;
            $display("FAIL pause_release: got (%0d,%0d) want (%0d,%0d)",
                     o_box_x, o_box_y, bx + 11'd2, by + 10'd2);
        end
        step(1, 0);
    endtask

    task automatic test_corner();
        int guard = 0;
        while (m_y != 566 && guard < 400) begin frame(); guard++; end
        n_checks++;
        if (c_box_x !== 11'd566 || c_box_y !== 10'd566) begin
            n_fail++;
            $display("FAIL corner_pre: got (%0d,%0d) want (566,566)", c_box_x, c_box_y);
        end
        step(0, 0);
        n_checks++;
        if (c_tick !== 1'b1 || c_box_x !== 11'd568 || c_box_y !== 10'd568) begin
            n_fail++;
            $display("FAIL corner_hit: got tick=%b box=(%0d,%0d) want 1 (568,568)",
                     c_tick, c_box_x, c_box_y);
        end
        step(1, 0);
        step(570, 570);
        n_checks++;
        if ({c_red, c_green, c_blue} !== 3'b101) begin
            n_fail++;
            $display("FAIL corner_colour: got %b want 101", {c_red, c_green, c_blue});
        end
        frame();
        n_checks++;
        if (c_box_x !== 11'd566 || c_box_y !== 10'd566) begin
            n_fail++;
            $display("FAIL corner_dir: got (%0d,%0d) want (566,566)", c_box_x, c_box_y);
        end
    endtask

    task automatic test_bounce_x();
        int guard = 0;
        int y_probe;
        while (!(m_x == 766 && !m_dxn) && guard < 400) begin frame(); guard++; end
        n_checks++;
        if (o_box_x !== 11'd766) begin
            n_fail++;
            $display("FAIL bx_pre: got %0d want 766", o_box_x);
        end
        step(0, 0);
        n_checks++;
        if (o_box_x !== 11'd768) begin
            n_fail++;
            $display("FAIL bx_clamp: got %0d want 768", o_box_x);
        end
        step(1, 0);
        y_probe = m_y + 1;
        step(770, y_probe);
        // Y bounced once earlier (100->101), so the X bounce takes it to 110.
        n_checks++;
        if ({o_red, o_green, o_blue} !== 3'b110) begin
            n_fail++;
            $display("FAIL bx_colour: got %b want 110", {o_red, o_green, o_blue});
        end
        step(0, 0);
        n_checks++;
        if (o_box_x !== 11'd766) begin
            n_fail++;
            $display("FAIL bx_return: got %0d want 766", o_box_x);
        end
        step(1, 0);
    endtask

    task automatic test_reset_mid();
        step(400, 300);
        i_reset = 1'b1;
        step(400, 300);
        n_checks++;
        if ({o_red, o_green, o_blue, o_frame_tick} !== 4'b0 || o_box_x !== 11'd0
            || o_box_y !== 10'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got rgb=%b tick=%b box=(%0d,%0d) want zeros",
                     {o_red, o_green, o_blue}, o_frame_tick, o_box_x, o_box_y);
        end
        i_reset = 1'b0;
        step(5, 5);
        n_checks++;
        if ({o_red, o_green, o_blue} !== 3'b100 || o_frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_colour: got rgb=%b tick=%b want 100 0",
                     {o_red, o_green, o_blue}, o_frame_tick);
        end
        step(0, 0);
        n_checks++;
        if (o_frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_next_fs: got %b want 1", o_frame_tick);
        end
        i_reset = 1'b1;
        step(0, 0);
        i_reset = 1'b0;
        step(0, 0);
        n_checks++;
        if (o_frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_at_origin: got %b want 0", o_frame_tick);
        end
    endtask

    initial begin
        m_x = 0; m_y = 0; m_dxn = 1'b0; m_dyn = 1'b0; m_col = 3'b100; m_prev = 1'b1;
        test_reset();
        test_frames();
        test_pixels();
        test_pause();
        test_corner();
        test_bounce_x();
        test_reset_mid();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
